// File: rtl/kfn_mem_pkg.sv
// Shared constants for the feature-SRAM access path: geometry, requester and response ids.
package kfn_mem_pkg;

   localparam int unsigned ADDR_W = 11;
   localparam int unsigned DATA_W = 128;

   localparam logic [1:0] REQ_WR  = 2'd0;
   localparam logic [1:0] REQ_RD0 = 2'd1;
   localparam logic [1:0] REQ_RD1 = 2'd2;

   localparam logic RSP_RD0 = 1'b0;
   localparam logic RSP_RD1 = 1'b1;

   // Successor in the 3-entry rotation; the unused code 3 folds onto 0's successor.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      logic [1:0] nxt;
      unique case (idx)
         REQ_WR:  nxt = REQ_RD0;
         REQ_RD0: nxt = REQ_RD1;
         REQ_RD1: nxt = REQ_WR;
         default: nxt = REQ_RD0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way rotating-priority picker: scans from rr_ptr and grants the first valid.
module rr_arbiter3
   import kfn_mem_pkg::*;
(
   input  logic [2:0] valid,
   input  logic [1:0] rr_ptr,
   output logic [2:0] grant,
   output logic [1:0] grant_idx,
   output logic       grant_any
);

   logic [1:0] scan_idx;

   always_comb begin
      grant     = '0;
      grant_idx = REQ_WR;
      grant_any = 1'b0;
      scan_idx  = (rr_ptr == 2'd3) ? REQ_WR : rr_ptr;
      for (int k = 0; k < 3; k++) begin
         if (!grant_any && valid[scan_idx]) begin
            grant[scan_idx] = 1'b1;
            grant_idx       = scan_idx;
            grant_any       = 1'b1;
         end
         scan_idx = rr_next(scan_idx);
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port feature SRAM between the loader write port and two read ports,
// round-robin, one access per cycle, tagged read responses one cycle after the grant.
module sram_port_arbiter
   import kfn_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = kfn_mem_pkg::ADDR_W,
   parameter int unsigned DATA_W = kfn_mem_pkg::DATA_W
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd0_valid,
   output logic              rd0_ready,
   input  logic [ADDR_W-1:0] rd0_addr,
   input  logic              rd1_valid,
   output logic              rd1_ready,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data,
   output logic              CEN,
   output logic              WEN,
   output logic [ADDR_W-1:0] A,
   output logic [DATA_W-1:0] D,
   input  logic [DATA_W-1:0] Q
);

   logic [1:0] rr_ptr_q, rr_ptr_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_id_q, rsp_id_d;

   logic [2:0] req_valid;
   logic [2:0] grant;
   logic [1:0] grant_idx;
   logic       grant_any;

   // Masking the requests during reset keeps all readies low and the SRAM deselected.
   assign req_valid = {rd1_valid, rd0_valid, wr_valid} & {3{~reset}};

   rr_arbiter3 u_rr_arbiter3 (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign wr_ready  = grant[REQ_WR];
   assign rd0_ready = grant[REQ_RD0];
   assign rd1_ready = grant[REQ_RD1];

   always_comb begin
      CEN = 1'b1;
      WEN = 1'b1;
      A   = '0;
      D   = '0;
      if (grant_any) begin
         CEN = 1'b0;
         unique case (grant_idx)
            REQ_WR: begin
               WEN = 1'b0;
               A   = wr_addr;
               D   = wr_data;
            end
            REQ_RD0: A = rd0_addr;
            REQ_RD1: A = rd1_addr;
            default: ;
         endcase
      end
   end

   always_comb begin
      rr_ptr_d    = grant_any ? rr_next(grant_idx) : rr_ptr_q;
      rsp_valid_d = grant_any && (grant_idx != REQ_WR);
      rsp_id_d    = rsp_id_q;
      if (rsp_valid_d) begin
         rsp_id_d = (grant_idx == REQ_RD1) ? RSP_RD1 : RSP_RD0;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         rr_ptr_q    <= REQ_WR;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= RSP_RD0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   // A read granted just before reset must not surface while reset is held.
   assign rsp_valid = rsp_valid_q & ~reset;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = Q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed scenarios plus randomized traffic,
// checked against a round-robin reference model and a shadow copy of the SRAM contents.
module tb_sram_port_arbiter;

   localparam int AW = 11;
   localparam int DW = 128;

   logic          CLK = 1'b0;
   logic          reset;
   logic          wr_valid, rd0_valid, rd1_valid;
   logic          wr_ready, rd0_ready, rd1_ready;
   logic [AW-1:0] wr_addr, rd0_addr, rd1_addr;
   logic [DW-1:0] wr_data;
   logic          rsp_valid, rsp_id;
   logic [DW-1:0] rsp_data;
   logic          CEN, WEN;
   logic [AW-1:0] A;
   logic [DW-1:0] D, Q;

   sram_port_arbiter dut (
      .CLK       (CLK),
      .reset     (reset),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd0_valid (rd0_valid),
      .rd0_ready (rd0_ready),
      .rd0_addr  (rd0_addr),
      .rd1_valid (rd1_valid),
      .rd1_ready (rd1_ready),
      .rd1_addr  (rd1_addr),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .CEN       (CEN),
      .WEN       (WEN),
      .A         (A),
      .D         (D),
      .Q         (Q)
   );

   always #5 CLK = ~CLK;

   // Behavioural single-port SRAM macro with registered read.
   logic [DW-1:0] sram [0:2047];
   logic [DW-1:0] q_r = '0;
   assign Q = q_r;
   always @(posedge CLK) begin
      if (!CEN) begin
         if (!WEN) sram[A] <= D;
         else      q_r <= sram[A];
      end
   end

   // Reference state
   logic [DW-1:0] ref_mem [0:2047];
   typedef struct {
      int            due;
      logic          id;
      logic [DW-1:0] data;
   } rsp_t;
   rsp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int m_ptr = 0;
   int m_grant = -1;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // Predictor: who should win this cycle and what the SRAM pins must show.
   always @(negedge CLK) begin
      logic [2:0]    v;
      logic [2:0]    exp_rdy;
      logic [AW-1:0] ea;
      int            g;
      v = {rd1_valid, rd0_valid, wr_valid};
      if (reset) begin
         chk("ready_in_reset", {rd1_ready, rd0_ready, wr_ready}, 3'b000);
         chk("cen_in_reset", CEN, 1'b1);
         chk("wen_in_reset", WEN, 1'b1);
         m_ptr   = 0;
         m_grant = -1;
      end else begin
         g = -1;
         for (int k = 0; k < 3; k++) begin
            if (g < 0 && v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
         end
         exp_rdy = 3'b000;
         if (g >= 0) exp_rdy[g] = 1'b1;
         ea = '0;
         if (g == 0) ea = wr_addr;
         if (g == 1) ea = rd0_addr;
         if (g == 2) ea = rd1_addr;
         chk("ready", {rd1_ready, rd0_ready, wr_ready}, exp_rdy);
         chk("cen", CEN, (g < 0) ? 1'b1 : 1'b0);
         chk("wen", WEN, (g == 0) ? 1'b0 : 1'b1);
         chk("addr", A, ea);
         if (g == 0) chk("wdata", D, wr_data);
         if (g < 0) chk("d_idle", D, '0);
         if (g >= 0) m_ptr = (g + 1) % 3;
         if (g == 0) ref_mem[wr_addr] = wr_data;
         if (g == 1) sb.push_back('{cyc + 1, 1'b0, ref_mem[rd0_addr]});
         if (g == 2) sb.push_back('{cyc + 1, 1'b1, ref_mem[rd1_addr]});
         m_grant = g;
      end
   end

   // Monitor: compare every response slot against the scoreboard.
   always @(negedge CLK) begin
      if (reset) begin
         chk("rsp_valid_in_reset", rsp_valid, 1'b0);
         while (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
         chk("rsp_valid", rsp_valid, 1'b1);
         chk("rsp_id", rsp_id, sb[0].id);
         chk("rsp_data", rsp_data, sb[0].data);
         void'(sb.pop_front());
      end else begin
         chk("rsp_quiet", rsp_valid, 1'b0);
      end
   end

   task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic v0, input logic [AW-1:0] a0,
                       input logic v1, input logic [AW-1:0] a1);
      wr_valid  = wv;
      wr_addr   = wa;
      wr_data   = wd;
      rd0_valid = v0;
      rd0_addr  = a0;
      rd1_valid = v1;
      rd1_addr  = a1;
      @(posedge CLK);
      #1;
   endtask

   logic [DW-1:0] pat_a5;
   logic [2:0]    pv;
   logic [AW-1:0] pa [3];
   logic [DW-1:0] pd;

   initial begin
      for (int i = 0; i < 2048; i++) begin
         sram[i]    = '0;
         ref_mem[i] = '0;
      end
      pat_a5 = {16{8'hA5}};
      reset  = 1'b1;

      // Reset held with everything requesting
      for (int i = 0; i < 3; i++) step(1'b1, 11'h005, 128'h1, 1'b1, 11'h006, 1'b1, 11'h007);
      reset = 1'b0;

      // Full contention, 9 cycles
      for (int i = 0; i < 9; i++) step(1'b1, 11'(i), 128'(i + 100), 1'b1, 11'(i), 1'b1, 11'(i));

      // Write then read same address
      step(1'b1, 11'h7FF, pat_a5, 1'b0, '0, 1'b0, '0);
      step(1'b0, '0, '0, 1'b1, 11'h7FF, 1'b0, '0);

      // Preload 0..3, then stream reads on rd1
      for (int i = 0; i < 4; i++) step(1'b1, 11'(i), 128'(10 + i), 1'b0, '0, 1'b0, '0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b1, 11'(i));

      // Move pointer to rd0, idle, then rd0 and wr together
      step(1'b1, 11'h100, 128'hBEEF, 1'b0, '0, 1'b0, '0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      step(1'b1, 11'h101, 128'hCAFE, 1'b1, 11'h100, 1'b0, '0);
      step(1'b1, 11'h101, 128'hCAFE, 1'b0, '0, 1'b0, '0);

      // Reset right after a read grant
      step(1'b0, '0, '0, 1'b1, 11'h7FF, 1'b0, '0);
      reset = 1'b1;
      step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      reset = 1'b0;
      step(1'b1, 11'h102, 128'h55, 1'b1, 11'h101, 1'b0, '0);
      step(1'b0, '0, '0, 1'b1, 11'h101, 1'b0, '0);

      // Randomized traffic with hold-until-granted requesters
      pv = 3'b000;
      pd = '0;
      for (int r = 0; r < 3; r++) pa[r] = '0;
      for (int i = 0; i < 400; i++) begin
         for (int r = 0; r < 3; r++) begin
            if (!pv[r] || m_grant == r) begin
               pv[r] = ($urandom_range(0, 99) < 55);
               pa[r] = 11'($urandom_range(0, 15));
               if (r == 0) pd = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
         end
         reset = ($urandom_range(0, 199) == 0);
         step(pv[0], pa[0], pd, pv[1], pa[1], pv[2], pa[2]);
      end
      reset = 1'b0;

      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      chk("scoreboard_drained", 128'(sb.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
